// File: rtl/line_delay_chain_if.sv
// Pixel stream in, aligned tap column out; master drives the stream, slave is the delay chain.
// No backpressure: the producer owns the pace through in_valid.
interface line_delay_chain_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_TAPS = 3
);
   logic                       in_valid;
   logic [DATA_W-1:0]          in_data;
   logic [NUM_TAPS*DATA_W-1:0] taps_o;
   logic                       out_valid;

   modport master (
      output in_valid,
      output in_data,
      input  taps_o,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output taps_o,
      output out_valid
   );
endinterface

// File: rtl/line_delay_chain.sv
// Multi-line delay feeding a NUM_TAPS-high window: tap k is the sample accepted k*DELAY samples ago.
// One cycle from accept to taps_o; no backpressure, every valid sample is taken unless flush is high.
module line_delay_chain #(
   parameter int DATA_W   = 8,
   parameter int DELAY    = 253,
   parameter int NUM_TAPS = 3
) (
   input  logic                                       clk,
   input  logic                                       nres,
   input  logic                                       flush,
   line_delay_chain_if.slave                          bus,
   output logic                                       primed,
   output logic [$clog2((NUM_TAPS-1)*DELAY+1)-1:0]    fill_cnt
);
   localparam int PRIME = (NUM_TAPS-1)*DELAY;
   localparam int FCW   = $clog2(PRIME+1);
   localparam int PTRW  = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam int TW    = NUM_TAPS*DATA_W;

   typedef enum logic {FILL, RUN} state_t;

   state_t            state_q, state_d;
   logic [PTRW-1:0]   ptr_q, ptr_d;
   logic [FCW-1:0]    fill_q, fill_d;
   logic              vld_q, vld_d;
   logic [TW-1:0]     taps_q, taps_d;
   logic              wr_en;

   logic [DATA_W-1:0] ram_q [NUM_TAPS-1][DELAY];
   logic [DATA_W-1:0] rd    [NUM_TAPS-1];

   always_comb begin
      for (int k = 0; k < NUM_TAPS-1; k++) begin
         rd[k] = ram_q[k][ptr_q];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      vld_d   = 1'b0;
      taps_d  = taps_q;
      wr_en   = 1'b0;
      if (flush) begin
         // A sample arriving with flush is dropped; taps keep their last column.
         state_d = FILL;
         ptr_d   = '0;
         fill_d  = '0;
      end else if (bus.in_valid) begin
         wr_en = 1'b1;
         taps_d[0 +: DATA_W] = bus.in_data;
         for (int k = 1; k < NUM_TAPS; k++) begin
            taps_d[k*DATA_W +: DATA_W] = rd[k-1];
         end
         ptr_d = (ptr_q == PTRW'(DELAY-1)) ? '0 : ptr_q + PTRW'(1);
         case (state_q)
            FILL: begin
               fill_d = fill_q + FCW'(1);
               if (fill_q == FCW'(PRIME-1)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               vld_d = 1'b1;
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nres) begin
         state_q <= FILL;
         ptr_q   <= '0;
         fill_q  <= '0;
         vld_q   <= 1'b0;
         taps_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         vld_q   <= vld_d;
         taps_q  <= taps_d;
      end
   end

   // Line storage is never cleared; stale words are flushed out before the first valid column.
   always_ff @(posedge clk) begin
      if (nres && wr_en) begin
         ram_q[0][ptr_q] <= bus.in_data;
         for (int k = 1; k < NUM_TAPS-1; k++) begin
            ram_q[k][ptr_q] <= rd[k-1];
         end
      end
   end

   assign bus.taps_o    = taps_q;
   assign bus.out_valid = vld_q;
   assign primed        = (state_q == RUN);
   assign fill_cnt      = fill_q;
endmodule
